result_readback_streamer: RTL

- Reads the result matrix that the systolic core writes to output BRAM, after the core has signalled done.
- Emits the matrix as a valid/ready word stream for the board-side consumer (UART/ILA/host bridge).
- It is the consumer of the core's memory write port: it issues BRAM reads from base_addr_out.
- Prefetches through a 2-entry buffer so that, with no backpressure, it sustains 1 word/cycle.

---
 rtl/result_readback_streamer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/result_readback_streamer.sv
// result_readback_streamer: reads a row-major result matrix from BRAM and streams it out.
// Latency: first rd_en 2 cycles after start, first beat 4 cycles after start, then 1 word/cycle.
// Backpressure: read credit against a 2-entry prefetch FIFO; tready=0 stalls reads, data never drops.
module result_readback_streamer #(
  parameter int MAT_SIZE_BITS = 4,
  parameter int BRAM_DEPTH    = 10,
  parameter int VAL_SIZE      = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [MAT_SIZE_BITS-1:0] M,
  input  logic [MAT_SIZE_BITS-1:0] K,
  input  logic [BRAM_DEPTH-1:0]    base_addr_out,
  output logic                     rd_en,
  output logic [BRAM_DEPTH-1:0]    rd_addr,
  input  logic [VAL_SIZE-1:0]      rd_data,
  output logic [VAL_SIZE-1:0]      tdata,
  output logic                     tvalid,
  input  logic                     tready,
  output logic                     tlast,
  output logic                     teol,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int TW = 2 * MAT_SIZE_BITS;
  localparam int SW = ((TW > BRAM_DEPTH) ? TW : BRAM_DEPTH) + 1;
  localparam int EW = VAL_SIZE + 2;  // {tlast, teol, data}

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t                   state_q, state_d;
  logic [MAT_SIZE_BITS-1:0] m_q, m_d, k_q, k_d, col_q, col_d;
  logic [BRAM_DEPTH-1:0]    addr_q, addr_d;
  logic [TW-1:0]            issued_q, issued_d;
  logic                     err_q, err_d;
  logic                     inflight_q, inflight_d;
  logic [1:0]               tag_q, tag_d;
  logic [EW-1:0]            mem_q [2];
  logic [EW-1:0]            mem_d [2];
  logic                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]               cnt_q, cnt_d;

  logic [TW-1:0] total;
  logic [SW-1:0] end_addr;
  logic          ovf, pop, issue_last, issue_eol, drain_empty;
  logic [2:0]    occ;
  logic [EW-1:0] head;

  // Matrix geometry, bounds check and read-credit accounting.
  always_comb begin
    total       = TW'(m_q) * TW'(k_q);
    end_addr    = SW'(addr_q) + SW'(total);
    ovf         = end_addr > (SW'(1) << BRAM_DEPTH);
    head        = mem_q[rd_ptr_q];
    tvalid      = (cnt_q != 2'd0);
    pop         = tvalid && tready;
    // Words already owned by the FIFO or on their way in, after this cycle's pop.
    occ         = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue_last  = (issued_q == total - TW'(1));
    issue_eol   = (col_q == k_q - MAT_SIZE_BITS'(1));
    drain_empty = !inflight_q && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop));
  end

  // Control FSM: next state, read issue and latched request fields.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    k_d        = k_q;
    col_d      = col_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    err_d      = err_q;
    rd_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d      = M;
          k_d      = K;
          addr_d   = base_addr_out;
          err_d    = 1'b0;
          issued_d = '0;
          col_d    = '0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (total == '0) begin
          state_d = S_FIN;
        end else if (ovf) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (occ < 3'd2) begin
          rd_en    = 1'b1;
          addr_d   = addr_q + BRAM_DEPTH'(1);
          issued_d = issued_q + TW'(1);
          col_d    = issue_eol ? '0 : col_q + MAT_SIZE_BITS'(1);
          if (issue_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_empty) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prefetch FIFO: capture read data one cycle after issue, retire on handshake.
  always_comb begin
    inflight_d = rd_en;
    tag_d      = {rd_en && issue_last, rd_en && issue_eol};
    mem_d[0]   = mem_q[0];
    mem_d[1]   = mem_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    if (inflight_q) begin
      mem_d[wr_ptr_q] = {tag_q, rd_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
  end

  // State registers; reset aborts any transfer and empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      k_q        <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      k_q        <= k_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      mem_q[0]   <= mem_d[0];
      mem_q[1]   <= mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output decode; markers are gated so a stale head never shows tlast/teol.
  always_comb begin
    rd_addr = addr_q;
    tdata   = head[VAL_SIZE-1:0];
    tlast   = tvalid && head[EW-1];
    teol    = tvalid && head[EW-2];
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIN);
    err     = err_q;
  end

endmodule
